// File: rtl/register_display_reader.sv
// Register display reader: captures one register-file value and converts it
// serially (double-dabble, one shift per clock) into five packed BCD digits plus sign.
module register_display_reader #(
    parameter int SIGNED_MODE = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  reg_sel,
    output logic [3:0]  rd_addr,
    input  logic [15:0] rd_data,
    output logic        busy,
    output logic        done,
    output logic [19:0] bcd,
    output logic        sign,
    output logic [3:0]  shown_reg
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_CONV  = 2'd2
    } state_t;

    state_t      r_state;
    logic [3:0]  r_rd_addr;
    logic [3:0]  r_sel;
    logic        r_busy;
    logic        r_done;
    logic [19:0] r_bcd_out;
    logic        r_sign_out;
    logic [3:0]  r_shown;
    logic [15:0] r_bin;
    logic [19:0] r_bcd_work;
    logic        r_sign_work;
    logic [3:0]  r_cnt;

    logic        w_neg;
    logic [15:0] w_mag;
    logic [19:0] w_adj;
    logic [35:0] w_shift;

    // Pre-shift correction: every digit of 5 or more gets +3 so the shift carries into the next digit.
    function automatic logic [19:0] dabble_adjust(input logic [19:0] b);
        logic [19:0] r;
        r = 20'd0;
        for (int i = 0; i < 5; i++) begin
            if (b[i*4 +: 4] >= 4'd5) begin
                r[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
            end else begin
                r[i*4 +: 4] = b[i*4 +: 4];
            end
        end
        return r;
    endfunction

    // Magnitude/sign of the captured value and the next double-dabble step.
    always_comb begin
        w_neg   = (SIGNED_MODE != 0) && rd_data[15];
        w_mag   = w_neg ? (~rd_data + 16'd1) : rd_data;
        w_adj   = dabble_adjust(r_bcd_work);
        w_shift = {w_adj, r_bin} << 1;
    end

    // Control FSM, conversion datapath and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_rd_addr   <= 4'd0;
            r_sel       <= 4'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_bcd_out   <= 20'd0;
            r_sign_out  <= 1'b0;
            r_shown     <= 4'd0;
            r_bin       <= 16'd0;
            r_bcd_work  <= 20'd0;
            r_sign_work <= 1'b0;
            r_cnt       <= 4'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_rd_addr <= reg_sel;
                        r_sel     <= reg_sel;
                        r_busy    <= 1'b1;
                        r_state   <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    r_bin       <= w_mag;
                    r_sign_work <= w_neg;
                    r_bcd_work  <= 20'd0;
                    r_cnt       <= 4'd0;
                    r_state     <= ST_CONV;
                end
                ST_CONV: begin
                    r_bcd_work <= w_shift[35:16];
                    r_bin      <= w_shift[15:0];
                    r_cnt      <= r_cnt + 4'd1;
                    // Outputs change only on the final shift, so partial results stay hidden.
                    if (r_cnt == 4'd15) begin
                        r_bcd_out  <= w_shift[35:16];
                        r_sign_out <= r_sign_work;
                        r_shown    <= r_sel;
                        r_done     <= 1'b1;
                        r_busy     <= 1'b0;
                        r_state    <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign rd_addr   = r_rd_addr;
    assign busy      = r_busy;
    assign done      = r_done;
    assign bcd       = r_bcd_out;
    assign sign      = r_sign_out;
    assign shown_reg = r_shown;

endmodule

// File: tb/tb_register_display_reader.sv
// Self-checking bench: signed and unsigned instances share one register-file model
// and are compared against a decimal-arithmetic reference.
module tb_register_display_reader;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  reg_sel;
    logic [15:0] regfile [16];

    logic [3:0]  rd_addr_s, rd_addr_u, shown_s, shown_u;
    logic [15:0] rd_data_s, rd_data_u;
    logic        busy_s, busy_u, done_s, done_u, sign_s, sign_u;
    logic [19:0] bcd_s, bcd_u;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int done_q[$];

    always #5 clock = ~clock;

    always_comb begin
        rd_data_s = regfile[rd_addr_s];
        rd_data_u = regfile[rd_addr_u];
    end

    register_display_reader #(.SIGNED_MODE(1)) dut_s (
        .clock(clock), .reset(reset), .start(start), .reg_sel(reg_sel),
        .rd_addr(rd_addr_s), .rd_data(rd_data_s), .busy(busy_s), .done(done_s),
        .bcd(bcd_s), .sign(sign_s), .shown_reg(shown_s)
    );

    register_display_reader #(.SIGNED_MODE(0)) dut_u (
        .clock(clock), .reset(reset), .start(start), .reg_sel(reg_sel),
        .rd_addr(rd_addr_u), .rd_data(rd_data_u), .busy(busy_u), .done(done_u),
        .bcd(bcd_u), .sign(sign_u), .shown_reg(shown_u)
    );

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (done_s) done_q.push_back(cyc);
    end

    // Reference: {sign, five BCD digits} computed with decimal arithmetic.
    function automatic logic [20:0] ref_disp(input logic [15:0] v, input bit sgn);
        int          mag;
        logic        s;
        logic [19:0] b;
        if (sgn && v[15]) begin
            mag = 65536 - int'(v);
            s   = 1'b1;
        end else begin
            mag = int'(v);
            s   = 1'b0;
        end
        b = 20'd0;
        for (int d = 0; d < 5; d++) begin
            b[d*4 +: 4] = 4'(mag % 10);
            mag = mag / 10;
        end
        return {s, b};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_results(input logic [3:0] sel, input logic [15:0] val);
        logic [20:0] e_s, e_u;
        e_s = ref_disp(val, 1'b1);
        e_u = ref_disp(val, 1'b0);
        check_eq("bcd_signed",    32'(bcd_s),   32'(e_s[19:0]));
        check_eq("sign_signed",   32'(sign_s),  32'(e_s[20]));
        check_eq("bcd_unsigned",  32'(bcd_u),   32'(e_u[19:0]));
        check_eq("sign_unsigned", 32'(sign_u),  32'(e_u[20]));
        check_eq("shown_signed",  32'(shown_s), 32'(sel));
        check_eq("shown_unsigned",32'(shown_u), 32'(sel));
    endtask

    // Wait (bounded) for the done pulse; returns number of edges waited.
    task automatic wait_done(output int edges, output bit seen);
        seen  = 1'b0;
        edges = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            edges++;
            if (done_s) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic display(input logic [3:0] sel);
        logic [15:0] val;
        int          nb;
        bit          seen;
        val     = regfile[sel];
        start   = 1'b1;
        reg_sel = sel;
        tick();
        start = 1'b0;
        check_eq("rd_addr_after_e0", 32'(rd_addr_s), 32'(sel));
        check_eq("busy_after_e0",    32'(busy_s),    32'd1);
        nb   = 1;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (done_s) begin
                seen = 1'b1;
                break;
            end
            if (busy_s) nb++;
        end
        check_eq("done_seen",       32'(seen),   32'd1);
        check_eq("busy_cycles",     32'(nb),     32'd17);
        check_eq("busy_low_at_done",32'(busy_s), 32'd0);
        check_eq("done_unsigned",   32'(done_u), 32'd1);
        check_results(sel, val);
        tick();
        check_eq("done_single_pulse", 32'(done_s), 32'd0);
    endtask

    logic [15:0] specials [6];

    initial begin
        int          n0, edges;
        bit          seen;
        logic [3:0]  sa;
        logic [15:0] old;

        specials[0] = 16'hFFFF;
        specials[1] = 16'h8000;
        specials[2] = 16'h7FFF;
        specials[3] = 16'h0000;
        specials[4] = 16'h0013;
        specials[5] = 16'h0001;
        for (int i = 0; i < 16; i++) regfile[i] = 16'($urandom);

        reset   = 1'b1;
        start   = 1'b0;
        reg_sel = 4'd0;
        tick();
        tick();
        check_eq("rst_bcd",     32'(bcd_s),     32'd0);
        check_eq("rst_sign",    32'(sign_s),    32'd0);
        check_eq("rst_busy",    32'(busy_s),    32'd0);
        check_eq("rst_done",    32'(done_s),    32'd0);
        check_eq("rst_rd_addr", 32'(rd_addr_s), 32'd0);
        check_eq("rst_shown",   32'(shown_s),   32'd0);
        check_eq("rst_bcd_u",   32'(bcd_u),     32'd0);
        reset = 1'b0;
        tick();

        // Basic display of R5 = 0x0013
        regfile[5] = 16'h0013;
        display(4'd5);
        check_eq("basic_bcd", 32'(bcd_s), 32'h00019);

        // Boundary values through several registers
        for (int i = 0; i < 6; i++) begin
            regfile[4'(i + 7)] = specials[i];
            display(4'(i + 7));
        end

        // Randomized registers and contents
        for (int i = 0; i < 20; i++) begin
            sa = 4'($urandom_range(0, 15));
            regfile[sa] = 16'($urandom);
            display(sa);
        end

        // Start during conversion is ignored
        regfile[3] = 16'd1234;
        regfile[9] = 16'd4321;
        n0      = done_q.size();
        start   = 1'b1;
        reg_sel = 4'd3;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        start   = 1'b1;
        reg_sel = 4'd9;
        tick();
        start = 1'b0;
        for (int k = 0; k < 40; k++) tick();
        check_eq("ignored_start_dones", 32'(done_q.size() - n0), 32'd1);
        check_results(4'd3, 16'd1234);

        // Held start gives one completion every 18 cycles
        n0      = done_q.size();
        start   = 1'b1;
        reg_sel = 4'd3;
        for (int k = 0; k < 60; k++) tick();
        start = 1'b0;
        for (int k = 0; k < 40 && busy_s; k++) tick();
        check_eq("held_idle", 32'(busy_s), 32'd0);
        check_eq("held_pulses_ge3", 32'((done_q.size() - n0) >= 3), 32'd1);
        for (int i = n0 + 1; i < done_q.size(); i++)
            check_eq("held_period", 32'(done_q[i] - done_q[i-1]), 32'd18);
        tick();

        // rd_data change after capture has no effect
        regfile[6] = 16'hFEDC;
        old        = regfile[6];
        start      = 1'b1;
        reg_sel    = 4'd6;
        tick();
        start = 1'b0;
        tick();
        regfile[6] = 16'h0042;
        wait_done(edges, seen);
        check_eq("late_change_done", 32'(seen), 32'd1);
        check_results(4'd6, old);
        tick();

        // Reset mid-conversion discards it
        regfile[2] = 16'd777;
        start      = 1'b1;
        reg_sel    = 4'd2;
        tick();
        start = 1'b0;
        for (int k = 0; k < 7; k++) tick();
        reset = 1'b1;
        tick();
        check_eq("midrst_busy",    32'(busy_s),    32'd0);
        check_eq("midrst_bcd",     32'(bcd_s),     32'd0);
        check_eq("midrst_sign",    32'(sign_s),    32'd0);
        check_eq("midrst_shown",   32'(shown_s),   32'd0);
        check_eq("midrst_rd_addr", 32'(rd_addr_s), 32'd0);
        reset = 1'b0;
        n0    = done_q.size();
        for (int k = 0; k < 30; k++) tick();
        check_eq("midrst_no_done", 32'(done_q.size() - n0), 32'd0);
        display(4'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/register_display_reader.md
# register_display_reader

Read-side companion to the CPU register file. On a display request it selects one register, captures its 16-bit value and converts it to five packed BCD digits plus a sign flag for the display stage. It sits between the CPU control path (the unit that issues DISPLAY operations) and the register file's combinational read port. Conversion is serial double-dabble, one shift per clock, under a start/busy/done handshake.

## Interface
Parameters:
- SIGNED_MODE, default 1: 1 = treat the register value as two's complement; 0 = treat it as unsigned.

Ports:
- clock  in  1  single system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clock.
- start  in  1  display request; sampled only in IDLE.
- reg_sel  in  4  index of the register to display (R0..R15).
- rd_addr  out  4  registered read address driven to the register-file read port.
- rd_data  in  16  combinational read data from the register file for rd_addr.
- busy  out  1  high from the start-accept edge until completion.
- done  out  1  one-cycle completion pulse.
- bcd  out  20  five BCD digits; [19:16] is the most significant digit, [3:0] the least significant.
- sign  out  1  1 = displayed value is negative.
- shown_reg  out  4  index of the register whose value is currently shown on bcd.

## Operation
- FSM states:
  - IDLE -> FETCH when start=1.
  - FETCH -> CONV, unconditionally.
  - CONV -> IDLE after the 16th shift.
- IDLE, start=1:
  - rd_addr <= reg_sel.
  - reg_sel is latched internally for shown_reg.
  - busy <= 1.
- FETCH: rd_data is captured into the shift register. Any later change to rd_data (LOAD or CLEAR to the register file) has no effect on the result.
- Magnitude rules:
  - SIGNED_MODE=1 and rd_data[15]=1: magnitude = (~rd_data + 1) as 16-bit unsigned, sign=1. 0x8000 gives 32768.
  - Otherwise: magnitude = rd_data, sign=0.
- CONV, each cycle: add 3 to every 4-bit BCD digit >= 5, then shift {bcd_work, bin_work} left by 1. Exactly 16 iterations, tracked by a 4-bit counter.
- Range: max 65535 (unsigned) or 32768 (signed), so no overflow into a sixth digit.
- Completion edge (end of the 16th shift):
  - bcd, sign and shown_reg update together.
  - done=1 for that one cycle.
  - busy=0.
  - state = IDLE.
- Between completions, bcd, sign and shown_reg hold their previous values. Intermediate conversion values never appear on the outputs.
- start while busy=1 is ignored; it is not queued.
- rd_addr holds its last value while in IDLE.

## Timing
- Reset values: rd_addr=0, busy=0, done=0, bcd=0, sign=0, shown_reg=0, state IDLE, counter 0.
- Start accepted at edge E0: busy=1 and rd_addr valid after E0.
- rd_data sampled at E1.
- Shifts occur at E2..E17.
- done/bcd/sign/shown_reg valid after E17. Latency is 17 cycles from start acceptance.
- busy deasserts after E17. A new start is accepted at E18 at the earliest, so start held high gives one conversion every 18 cycles.
- Reset asserted in any state:
  - Next edge returns every output to its reset value.
  - Any in-flight conversion is discarded; no done pulse.
  - Reset dominates start in the same cycle.

## Test plan
- Reset: assert reset for 2 cycles -> bcd=0x00000, sign=0, busy=0, done=0, rd_addr=0, shown_reg=0.
- Basic display: rd_data=0x0013 for R5; start=1 with reg_sel=5 for one cycle -> rd_addr=5 after E0; single done pulse after E17; bcd=0x00019, sign=0, shown_reg=5; busy high for exactly 17 cycles.
- Signed extremes with SIGNED_MODE=1:
  - rd_data=0xFFFF -> sign=1, bcd=0x00001.
  - rd_data=0x8000 -> sign=1, bcd=0x32768.
  - rd_data=0x7FFF -> sign=0, bcd=0x32767.
- Unsigned mode with SIGNED_MODE=0: rd_data=0xFFFF -> sign=0, bcd=0x65535; rd_data=0x0000 -> bcd=0x00000.
- Handshake: pulse start again 5 cycles into a conversion with a different reg_sel -> ignored, exactly one done, original shown_reg kept. Hold start high continuously -> done pulses exactly 18 cycles apart.
- Mid-operation events:
  - Change rd_data after E1 -> result reflects the value captured at E1.
  - Assert reset 8 cycles into a conversion -> busy=0 and bcd=0 next cycle, no done pulse; a following start converts normally.
